// File: rtl/spike_event_encoder.sv
// rtl/spike_event_encoder.sv - round-robin spike-to-address event encoder with output FIFO
module spike_event_encoder #(
  parameter int NUM_NEURONS      = 20,
  parameter int CLUSTER_ID_WIDTH = 7,
  parameter int NEURON_ID_WIDTH  = 5,
  parameter int CLUSTER_ID       = 0,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_NEURONS-1:0]                    spike_in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [CLUSTER_ID_WIDTH+NEURON_ID_WIDTH-1:0] out_addr,
  output logic                                      busy,
  output logic [15:0]                               drop_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int ADDR_W = CLUSTER_ID_WIDTH + NEURON_ID_WIDTH;
  localparam int NW     = NEURON_ID_WIDTH;
  localparam int PC_W   = $clog2(NUM_NEURONS + 1);

  // Pending spikes and arbitration state
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [NUM_NEURONS-1:0] grant_vec;
  logic [NUM_NEURONS-1:0] coalesce_vec;
  logic [NW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NW-1:0]          winner;
  logic [NW-1:0]          cand;
  logic [NW:0]            idx_wide;
  logic                   found;
  logic                   grant;

  // Event FIFO
  logic [ADDR_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]      push_data;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push;
  logic                   pop;

  // Coalesced-spike counter
  logic [15:0]            drop_count_q, drop_count_d;
  logic [PC_W-1:0]        coalesce_cnt;
  logic [16:0]            drop_sum;

  // Find the first pending neuron at or above rr_ptr, wrapping at the last neuron
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx_wide = '0;
    cand     = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      idx_wide = {1'b0, rr_ptr_q} + (NW+1)'(k);
      if (idx_wide >= (NW+1)'(NUM_NEURONS)) begin
        idx_wide = idx_wide - (NW+1)'(NUM_NEURONS);
      end
      cand = idx_wide[NW-1:0];
      if (!found && pending_q[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant only against the registered count so a same-cycle pop never admits an extra push
  always_comb begin
    grant     = found && (count_q < CNT_W'(FIFO_DEPTH));
    grant_vec = '0;
    if (grant) begin
      grant_vec[winner] = 1'b1;
    end
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (winner == NW'(NUM_NEURONS - 1)) ? '0 : winner + NW'(1);
    end
  end

  // A new spike re-arms pending; a spike onto a still-waiting bit is coalesced and counted
  always_comb begin
    pending_d    = (pending_q & ~grant_vec) | spike_in;
    coalesce_vec = spike_in & pending_q & ~grant_vec;
    coalesce_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      coalesce_cnt = coalesce_cnt + PC_W'(coalesce_vec[i]);
    end
    drop_sum     = {1'b0, drop_count_q} + 17'(coalesce_cnt);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  always_comb begin
    push      = grant;
    pop       = out_valid && out_ready;
    push_data = {CLUSTER_ID_WIDTH'(CLUSTER_ID), winner};
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Outputs come straight from registered state
  always_comb begin
    out_valid  = (count_q != '0);
    out_addr   = out_valid ? mem_q[rd_ptr_q] : '0;
    busy       = (pending_q != '0) || (count_q != '0);
    drop_count = drop_count_q;
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Event storage; contents need no reset because out_addr is masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// tb/tb_spike_event_encoder.sv - self-checking bench for spike_event_encoder
module tb_spike_event_encoder;

  localparam int N   = 20;
  localparam int CID = 5;
  localparam int DEP = 16;

  logic        clk;
  logic        reset;
  logic [19:0] spike_in;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addr;
  logic        busy;
  logic [15:0] drop_count;

  int n_pass;
  int n_total;

  spike_event_encoder #(
    .NUM_NEURONS(N), .CLUSTER_ID_WIDTH(7), .NEURON_ID_WIDTH(5),
    .CLUSTER_ID(CID), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .busy(busy), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending flags, event queue, round-robin start index, drop tally
  bit m_pend[N];
  int m_rr;
  int m_q[$];
  int m_drop;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_rr = 0;
    m_q.delete();
    m_drop = 0;
  endfunction

  function automatic void model_step(input logic [19:0] spk, input logic rdy);
    int  g;
    bit  pop;
    bit  done;
    pop  = (m_q.size() != 0) && rdy;
    g    = -1;
    done = 1'b0;
    if (m_q.size() < DEP) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!done && m_pend[j]) begin
          g    = j;
          done = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (spk[i] && m_pend[i] && i != g && m_drop < 65535) m_drop++;
      m_pend[i] = spk[i] || (m_pend[i] && i != g);
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(CID * 32 + g);
      m_rr = (g + 1) % N;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle(input logic [19:0] spk, input logic rdy);
    @(negedge clk);
    spike_in  = spk;
    out_ready = rdy;
    @(posedge clk);
    model_step(spk, rdy);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit any_p;
    int ev;
    any_p = 1'b0;
    for (int i = 0; i < N; i++) any_p |= m_pend[i];
    ev = (m_q.size() != 0) ? m_q[0] : 0;
    check({tag, " valid"}, out_valid, int'(m_q.size() != 0));
    check({tag, " addr"}, out_addr, ev);
    check({tag, " busy"}, busy, int'(any_p || m_q.size() != 0));
    check({tag, " drop"}, drop_count, m_drop);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    spike_in  = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [19:0] spike;
    logic        rdy;
    logic        exp_valid;
    logic [11:0] exp_addr;
    logic        exp_busy;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs[11];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    spike_in  = '0;
    out_ready = 1'b0;
    model_reset();

    // single event, round robin from rr_ptr=4, spike on the granted neuron
    vecs[0]  = '{20'h00008, 1'b1, 1'b0, 12'h000, 1'b1, 16'd0};
    vecs[1]  = '{20'h00000, 1'b1, 1'b1, 12'h0A3, 1'b1, 16'd0};
    vecs[2]  = '{20'h00000, 1'b1, 1'b0, 12'h000, 1'b0, 16'd0};
    vecs[3]  = '{20'h00022, 1'b1, 1'b0, 12'h000, 1'b1, 16'd0};
    vecs[4]  = '{20'h00000, 1'b1, 1'b1, 12'h0A5, 1'b1, 16'd0};
    vecs[5]  = '{20'h00000, 1'b1, 1'b1, 12'h0A1, 1'b1, 16'd0};
    vecs[6]  = '{20'h00000, 1'b1, 1'b0, 12'h000, 1'b0, 16'd0};
    vecs[7]  = '{20'h00004, 1'b1, 1'b0, 12'h000, 1'b1, 16'd0};
    vecs[8]  = '{20'h00004, 1'b1, 1'b1, 12'h0A2, 1'b1, 16'd0};
    vecs[9]  = '{20'h00000, 1'b1, 1'b1, 12'h0A2, 1'b1, 16'd0};
    vecs[10] = '{20'h00000, 1'b1, 1'b0, 12'h000, 1'b0, 16'd0};

    repeat (3) @(posedge clk);
    #1;
    check("reset valid", out_valid, 0);
    check("reset addr", out_addr, 0);
    check("reset busy", busy, 0);
    check("reset drop", drop_count, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].spike, vecs[i].rdy);
      check($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d addr", i), out_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d drop", i), drop_count, vecs[i].exp_drop);
    end

    // burst of all neurons with ready held high
    apply_reset();
    cycle(20'hFFFFF, 1'b1);
    check("burst first valid", out_valid, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(20'h0, 1'b1);
      check($sformatf("burst%0d valid", k), out_valid, 1);
      check($sformatf("burst%0d addr", k), out_addr, 12'h0A0 + k);
      check($sformatf("burst%0d busy", k), busy, 1);
    end
    cycle(20'h0, 1'b1);
    check("burst end valid", out_valid, 0);
    check("burst end busy", busy, 0);

    // backpressure fills the FIFO, then a coalesced spike on waiting neuron 17
    apply_reset();
    cycle(20'hFFFFF, 1'b0);
    repeat (16) cycle(20'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(20'h0, 1'b0);
      check($sformatf("stall%0d valid", k), out_valid, 1);
      check($sformatf("stall%0d addr", k), out_addr, 12'h0A0);
    end
    cycle(20'h20000, 1'b0);
    check("coalesce drop", drop_count, 1);
    check("coalesce addr", out_addr, 12'h0A0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("drain%0d valid", k), out_valid, 1);
      check($sformatf("drain%0d addr", k), out_addr, 12'h0A0 + k);
      cycle(20'h0, 1'b1);
    end
    check("drain end valid", out_valid, 0);
    check("drain end busy", busy, 0);
    check("drain end drop", drop_count, 1);

    // drop counter saturation
    apply_reset();
    cycle(20'hFFFFF, 1'b0);
    repeat (16) cycle(20'h0, 1'b0);
    cycle(20'hFFFFF, 1'b0);
    check("sat first drop", drop_count, 4);
    repeat (3300) cycle(20'hFFFFF, 1'b0);
    check("sat drop", drop_count, 16'hFFFF);
    check("sat addr", out_addr, 12'h0A0);

    // asynchronous reset in the middle of a backlog
    apply_reset();
    cycle(20'hFFFFF, 1'b0);
    repeat (8) cycle(20'h0, 1'b0);
    cycle(20'h80000, 1'b0);
    check("midreset pre drop", drop_count, 1);
    #2;
    reset    = 1'b1;
    spike_in = '0;
    #1;
    check("midreset valid", out_valid, 0);
    check("midreset busy", busy, 0);
    check("midreset drop", drop_count, 0);
    check("midreset addr", out_addr, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(20'h00080, 1'b1);
    check("post reset t+1 valid", out_valid, 0);
    check("post reset t+1 busy", busy, 1);
    cycle(20'h0, 1'b1);
    check("post reset t+2 valid", out_valid, 1);
    check("post reset t+2 addr", out_addr, 12'h0A7);
    cycle(20'h0, 1'b1);
    check("post reset t+3 valid", out_valid, 0);

    // randomized traffic against the reference model
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [19:0] spk;
      logic        rdy;
      case ((c / 150) % 4)
        0:       spk = 20'($urandom & $urandom & $urandom);
        1:       spk = 20'($urandom);
        2:       spk = ($urandom_range(0, 15) == 0) ? 20'hFFFFF : 20'h0;
        default: spk = 20'($urandom & $urandom);
      endcase
      case ((c / 100) % 3)
        0:       rdy = ($urandom_range(0, 3) != 0);
        1:       rdy = ($urandom_range(0, 3) == 0);
        default: rdy = 1'b1;
      endcase
      cycle(spk, rdy);
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
